// File: rtl/loop_nor_filt_pkg.sv
// Shared types and constants for the filtered loop-control NOR.
// Holds the output state encoding, default parameters and a width helper.
package loop_nor_pkg;

   typedef enum logic [1:0] {
      ST_HIGH    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_LOW     = 2'd2,
      ST_LATCHED = 2'd3
   } state_e;

   localparam int N_IN_DEF    = 2;
   localparam int DG_W_DEF    = 4;
   localparam int MIN_LOW_DEF = 8;
   localparam int TRIP_W_DEF  = 8;

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/loop_nor_filt_deglitch.sv
// One input bit: two-flop synchroniser followed by a run-length deglitch.
// q only moves after the synced value has disagreed with it for dg_len+1 edges.
module loop_deglitch #(
   parameter int DG_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            d,
   input  logic [DG_W-1:0] dg_len,
   output logic            q
);

   logic            sync1_q;
   logic            s_q;
   logic [DG_W-1:0] cnt_q, cnt_d;
   logic            q_q, q_d;

   // cnt never exceeds dg_len, so the increment cannot wrap.
   always_comb begin
      cnt_d = '0;
      q_d   = q_q;
      if (s_q != q_q) begin
         if (cnt_q >= dg_len) begin
            q_d = ~q_q;
         end else begin
            cnt_d = cnt_q + DG_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         cnt_q   <= '0;
         q_q     <= 1'b0;
      end else begin
         sync1_q <= d;
         s_q     <= sync1_q;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/loop_nor_filt.sv
// N-input NOR of deglitched comparator inputs with minimum-low hold,
// optional latched trip and a saturating trip counter. CELV/CELG/SUB are pins only.
module loop_nor_filt
   import loop_nor_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int DG_W    = DG_W_DEF,
   parameter int MIN_LOW = MIN_LOW_DEF,
   parameter int TRIP_W  = TRIP_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CELV,
   input  logic              CELG,
   input  logic              SUB,
   input  logic [N_IN-1:0]   i,
   input  logic [DG_W-1:0]   dg_len,
   input  logic              mode,
   input  logic              clr,
   output logic              o,
   output logic [N_IN-1:0]   flt,
   output logic              latched,
   output logic [TRIP_W-1:0] trip_cnt
);

   localparam int                 HOLD_W    = clog2(MIN_LOW);
   localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(MIN_LOW - 1);

   for (genvar k = 0; k < N_IN; k++) begin : g_dg
      loop_deglitch #(.DG_W(DG_W)) u_dg (
         .clk    (clk),
         .rst    (rst),
         .d      (i[k]),
         .dg_len (dg_len),
         .q      (flt[k])
      );
   end

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [TRIP_W-1:0]   trip_q, trip_d, trip_base;
   logic                o_q, latched_q;
   logic                any;

   assign any = |flt;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      trip_base = clr ? '0 : trip_q;
      trip_d    = trip_base;
      case (state_q)
         ST_HIGH: begin
            // A trip on the same edge as clr counts from zero.
            if (any) begin
               state_d = ST_HOLD;
               hold_d  = HOLD_INIT;
               trip_d  = (&trip_base) ? trip_base : trip_base + TRIP_W'(1);
            end
         end
         ST_HOLD: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HOLD_W'(1);
            end else if (mode) begin
               state_d = ST_LATCHED;
            end else if (!any) begin
               state_d = ST_HIGH;
            end else begin
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (!any) state_d = ST_HIGH;
         end
         ST_LATCHED: begin
            if (clr && !any) state_d = ST_HIGH;
         end
         default: state_d = ST_HIGH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_HIGH;
         hold_q    <= '0;
         trip_q    <= '0;
         o_q       <= 1'b1;
         latched_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         trip_q    <= trip_d;
         o_q       <= (state_d == ST_HIGH);
         latched_q <= (state_d == ST_LATCHED);
      end
   end

   assign o        = o_q;
   assign latched  = latched_q;
   assign trip_cnt = trip_q;

endmodule
